// File: rtl/soc_system_pio_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : soc_system_pio_gen
// Brief   : Avalon-MM GPIO bank: per-bit direction, set/clear, edge capture, IRQ.
// Revision: 1.0 - initial release
// ============================================================================
module soc_system_pio_gen #(
    parameter int                    DATA_WIDTH  = 16,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0,
    parameter int                    EDGE_TYPE   = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [2:0]            address,
    input  logic                  chipselect,
    input  logic                  read_n,
    input  logic                  write_n,
    input  logic [31:0]           writedata,
    output logic [31:0]           readdata,
    input  logic [DATA_WIDTH-1:0] in_port,
    output logic [DATA_WIDTH-1:0] out_port,
    output logic [DATA_WIDTH-1:0] oe,
    output logic                  irq
);

    localparam logic [2:0] c_ADDR_DATA    = 3'd0;
    localparam logic [2:0] c_ADDR_DIR     = 3'd1;
    localparam logic [2:0] c_ADDR_IRQMASK = 3'd2;
    localparam logic [2:0] c_ADDR_EDGECAP = 3'd3;
    localparam logic [2:0] c_ADDR_OUTSET  = 3'd4;
    localparam logic [2:0] c_ADDR_OUTCLR  = 3'd5;

    logic [DATA_WIDTH-1:0] r_data_out;
    logic [DATA_WIDTH-1:0] r_dir;
    logic [DATA_WIDTH-1:0] r_irq_mask;
    logic [DATA_WIDTH-1:0] r_edge_cap;
    logic [DATA_WIDTH-1:0] r_s1;
    logic [DATA_WIDTH-1:0] r_sync;
    logic [DATA_WIDTH-1:0] r_prev;
    logic [31:0]           r_readdata;

    logic                  w_wr;
    logic                  w_rd;
    logic [DATA_WIDTH-1:0] w_wd;
    logic [DATA_WIDTH-1:0] w_edge;
    logic [DATA_WIDTH-1:0] w_clr;
    logic [DATA_WIDTH-1:0] w_rd_val;
    logic [31:0]           w_rd_word;

    assign w_wr = chipselect & ~write_n;
    assign w_rd = chipselect & ~read_n;
    assign w_wd = writedata[DATA_WIDTH-1:0];

    generate
        if (DATA_WIDTH < 32) begin : g_wd_upper
            logic w_unused_wd;
            assign w_unused_wd = ^writedata[31:DATA_WIDTH];
        end
    endgenerate

    generate
        if (EDGE_TYPE == 0) begin : g_rise
            assign w_edge = r_sync & ~r_prev;
        end else if (EDGE_TYPE == 1) begin : g_fall
            assign w_edge = ~r_sync & r_prev;
        end else begin : g_any
            assign w_edge = r_sync ^ r_prev;
        end
    endgenerate

    assign w_clr = (w_wr && address == c_ADDR_EDGECAP) ? w_wd : '0;

    always_comb begin
        w_rd_val = '0;
        case (address)
            c_ADDR_DATA:    w_rd_val = (r_dir & r_data_out) | (~r_dir & r_sync);
            c_ADDR_DIR:     w_rd_val = r_dir;
            c_ADDR_IRQMASK: w_rd_val = r_irq_mask;
            c_ADDR_EDGECAP: w_rd_val = r_edge_cap;
            default:        w_rd_val = '0;
        endcase
    end

    always_comb begin
        w_rd_word                 = '0;
        w_rd_word[DATA_WIDTH-1:0] = w_rd_val;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_data_out <= RESET_VALUE;
            r_dir      <= '0;
            r_irq_mask <= '0;
            r_edge_cap <= '0;
            r_s1       <= '0;
            r_sync     <= '0;
            r_prev     <= '0;
            r_readdata <= '0;
        end else begin
            r_s1       <= in_port;
            r_sync     <= r_s1;
            r_prev     <= r_sync;
            // New edges are OR-ed in after the clear so a coincident edge survives.
            r_edge_cap <= (r_edge_cap & ~w_clr) | w_edge;
            if (w_wr) begin
                case (address)
                    c_ADDR_DATA:    r_data_out <= w_wd;
                    c_ADDR_DIR:     r_dir      <= w_wd;
                    c_ADDR_IRQMASK: r_irq_mask <= w_wd;
                    c_ADDR_OUTSET:  r_data_out <= r_data_out | w_wd;
                    c_ADDR_OUTCLR:  r_data_out <= r_data_out & ~w_wd;
                    default:        ;
                endcase
            end
            if (w_rd) begin
                r_readdata <= w_rd_word;
            end
        end
    end

    assign readdata = r_readdata;
    assign out_port = r_data_out;
    assign oe       = r_dir;
    assign irq      = |(r_edge_cap & r_irq_mask);

endmodule
`default_nettype wire

// File: tb/tb_soc_system_pio_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : tb_soc_system_pio_gen
// Brief   : Directed bench; rising-edge instance (A) and falling-edge instance (F).
// Revision: 1.0 - initial release
// ============================================================================
module tb_soc_system_pio_gen;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  address;
    logic        chipselect;
    logic        read_n;
    logic        write_n;
    logic [31:0] writedata;
    logic [15:0] in_port;
    logic [31:0] rd_a, rd_f;
    logic [15:0] out_a, out_f, oe_a, oe_f;
    logic        irq_a, irq_f;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    soc_system_pio_gen #(.DATA_WIDTH(16), .RESET_VALUE(16'hA5A5), .EDGE_TYPE(0)) dut (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .read_n(read_n), .write_n(write_n), .writedata(writedata), .readdata(rd_a),
        .in_port(in_port), .out_port(out_a), .oe(oe_a), .irq(irq_a)
    );

    soc_system_pio_gen #(.DATA_WIDTH(16), .RESET_VALUE(16'h0000), .EDGE_TYPE(1)) dut_f (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .read_n(read_n), .write_n(write_n), .writedata(writedata), .readdata(rd_f),
        .in_port(in_port), .out_port(out_f), .oe(oe_f), .irq(irq_f)
    );

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bus_idle();
        chipselect = 1'b0; read_n = 1'b1; write_n = 1'b1;
        address = 3'd0; writedata = 32'h0;
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        chipselect = 1'b1; write_n = 1'b0; read_n = 1'b1; address = a; writedata = d;
        step(1);
        bus_idle();
    endtask

    task automatic bus_read(input logic [2:0] a);
        chipselect = 1'b1; read_n = 1'b0; write_n = 1'b1; address = a;
        step(1);
        bus_idle();
    endtask

    task automatic test_reset();
        reset = 1'b1; in_port = 16'h0; bus_idle();
        step(3);
        reset = 1'b0;
        step(1);
        checks++; if (out_a !== 16'hA5A5) begin errors++; $display("FAIL reset_out got %h exp A5A5", out_a); end
        checks++; if (oe_a !== 16'h0) begin errors++; $display("FAIL reset_oe got %h exp 0000", oe_a); end
        checks++; if (irq_a !== 1'b0) begin errors++; $display("FAIL reset_irq got %b exp 0", irq_a); end
        checks++; if (rd_a !== 32'h0) begin errors++; $display("FAIL reset_readdata got %h exp 0", rd_a); end
        bus_read(3'd3);
        checks++; if (rd_a !== 32'h0) begin errors++; $display("FAIL reset_edgecap got %h exp 0", rd_a); end
    endtask

    task automatic test_set_clear();
        bus_write(3'd0, 32'hFFFF00F0);
        checks++; if (out_a !== 16'h00F0) begin errors++; $display("FAIL wr_data got %h exp 00F0", out_a); end
        bus_write(3'd4, 32'h0000000F);
        checks++; if (out_a !== 16'h00FF) begin errors++; $display("FAIL outset got %h exp 00FF", out_a); end
        bus_write(3'd5, 32'h00000030);
        checks++; if (out_a !== 16'h00CF) begin errors++; $display("FAIL outclr got %h exp 00CF", out_a); end
        checks++; if (out_f !== 16'h00CF) begin errors++; $display("FAIL outclr_f got %h exp 00CF", out_f); end
        bus_write(3'd1, 32'hFFFF0003);
        bus_read(3'd1);
        checks++; if (rd_a !== 32'h00000003) begin errors++; $display("FAIL dir_upper got %h exp 00000003", rd_a); end
        checks++; if (oe_a !== 16'h0003) begin errors++; $display("FAIL oe got %h exp 0003", oe_a); end
        bus_read(3'd4);
        checks++; if (rd_a !== 32'h0) begin errors++; $display("FAIL outset_read got %h exp 0", rd_a); end
        bus_read(3'd1);
        bus_read(3'd6);
        checks++; if (rd_a !== 32'h0) begin errors++; $display("FAIL reserved_read got %h exp 0", rd_a); end
        bus_write(3'd7, 32'h0000FFFF);
        checks++; if (out_a !== 16'h00CF || oe_a !== 16'h0003) begin errors++; $display("FAIL reserved_write got out %h oe %h exp 00CF 0003", out_a, oe_a); end
        bus_write(3'd1, 32'h0);
    endtask

    task automatic test_edge_irq();
        bus_write(3'd2, 32'h0001);
        in_port = 16'h0001;
        step(2);
        checks++; if (irq_a !== 1'b0) begin errors++; $display("FAIL irq_early got %b exp 0", irq_a); end
        step(1);
        checks++; if (irq_a !== 1'b1) begin errors++; $display("FAIL irq_rise got %b exp 1", irq_a); end
        bus_read(3'd3);
        checks++; if (rd_a !== 32'h1) begin errors++; $display("FAIL edgecap got %h exp 1", rd_a); end
        bus_write(3'd3, 32'h1);
        checks++; if (irq_a !== 1'b0) begin errors++; $display("FAIL irq_clear got %b exp 0", irq_a); end
    endtask

    task automatic test_simultaneous();
        in_port = 16'h0009;
        step(2);
        bus_write(3'd3, 32'h8);
        bus_read(3'd3);
        checks++; if (rd_a !== 32'h8) begin errors++; $display("FAIL edge_vs_clear got %h exp 8", rd_a); end
        bus_write(3'd3, 32'h8);
        bus_read(3'd3);
        checks++; if (rd_a !== 32'h0) begin errors++; $display("FAIL edge_clear2 got %h exp 0", rd_a); end
    endtask

    task automatic test_dir_mux();
        // Read and write to DIR in one cycle: read sees the old value.
        chipselect = 1'b1; read_n = 1'b0; write_n = 1'b0; address = 3'd1; writedata = 32'h00FF;
        step(1);
        bus_idle();
        checks++; if (rd_a !== 32'h0) begin errors++; $display("FAIL rw_same got %h exp 0", rd_a); end
        checks++; if (oe_a !== 16'h00FF) begin errors++; $display("FAIL rw_same_oe got %h exp 00FF", oe_a); end
        bus_write(3'd0, 32'h1234);
        in_port = 16'hABCD;
        step(2);
        bus_read(3'd0);
        checks++; if (rd_a !== 32'h0000AB34) begin errors++; $display("FAIL dir_mux got %h exp 0000AB34", rd_a); end
        checks++; if (rd_f !== 32'h0000AB34) begin errors++; $display("FAIL dir_mux_f got %h exp 0000AB34", rd_f); end
        step(2);
        checks++; if (rd_a !== 32'h0000AB34) begin errors++; $display("FAIL rd_hold got %h exp 0000AB34", rd_a); end
    endtask

    task automatic test_reset_midop();
        in_port = 16'h0005;
        step(4);
        bus_write(3'd3, 32'hFFFF);
        bus_write(3'd2, 32'h0005);
        in_port = 16'h0000;
        step(3);
        checks++; if (irq_f !== 1'b1) begin errors++; $display("FAIL fall_irq got %b exp 1", irq_f); end
        bus_read(3'd3);
        checks++; if (rd_f !== 32'h5) begin errors++; $display("FAIL fall_edgecap got %h exp 5", rd_f); end
        // Write pending during reset must be discarded.
        reset = 1'b1;
        chipselect = 1'b1; write_n = 1'b0; address = 3'd1; writedata = 32'hFFFF;
        step(1);
        bus_idle();
        reset = 1'b0;
        checks++; if (irq_f !== 1'b0 || oe_f !== 16'h0 || out_f !== 16'h0 || rd_f !== 32'h0) begin
            errors++; $display("FAIL midop_reset got irq %b oe %h out %h rd %h exp 0", irq_f, oe_f, out_f, rd_f);
        end
        bus_read(3'd3);
        checks++; if (rd_f !== 32'h0) begin errors++; $display("FAIL midop_edgecap got %h exp 0", rd_f); end
        in_port = 16'h0002;
        step(4);
        in_port = 16'h0000;
        step(3);
        bus_read(3'd3);
        checks++; if (rd_f !== 32'h2) begin errors++; $display("FAIL post_reset_fall got %h exp 2", rd_f); end
        bus_write(3'd2, 32'h0002);
        checks++; if (irq_f !== 1'b1) begin errors++; $display("FAIL post_reset_irq got %b exp 1", irq_f); end
    endtask

    initial begin
        test_reset();
        test_set_clear();
        test_edge_irq();
        test_simultaneous();
        test_dir_mux();
        test_reset_midop();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
